// File: rtl/mult_arbiter_pkg.sv
// ==== mult_arb_pkg : shared types, defaults and bus helper for mult_arbiter (rev 1.0) ====
`default_nettype none

package mult_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      LAUNCH = 2'b01,
      WAIT   = 2'b10,
      RESP   = 2'b11
   } arb_state_t;

   localparam int DEF_NUM_REQ = 4;
   localparam int DEF_WIDTH   = 16;
   localparam int DEF_TIMEOUT = 64;

   // Largest packed request bus the slice helper accepts (8 requesters x 32 bits).
   localparam int MAX_REQ = 8;
   localparam int MAX_W   = 32;
   localparam int MAX_BUS = MAX_REQ * MAX_W;

   function automatic logic [MAX_W-1:0] bus_slice(
      input logic [MAX_BUS-1:0] bus,
      input int unsigned        idx,
      input int unsigned        w
   );
      logic [MAX_BUS-1:0] shifted;
      logic [MAX_W-1:0]   mask;
      shifted = bus >> (idx * w);
      mask    = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
      return shifted[MAX_W-1:0] & mask;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mult_arbiter_if.sv
// ==== mult_arbiter_if : client, multiplier and response signals of mult_arbiter (rev 1.0) ====
`default_nettype none

interface mult_arbiter_if
   import mult_arb_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int ID_W    = 2,
   parameter int WIDTH   = DEF_WIDTH
);
   logic [NUM_REQ-1:0]       req;
   logic [NUM_REQ*WIDTH-1:0] req_mer;
   logic [NUM_REQ*WIDTH-1:0] req_mand;
   logic [NUM_REQ-1:0]       gnt;

   logic                     mult_go;
   logic [WIDTH-1:0]         mult_mer;
   logic [WIDTH-1:0]         mult_mand;
   logic [2*WIDTH-1:0]       mult_product;
   logic                     mult_done;

   logic                     resp_valid;
   logic [ID_W-1:0]          resp_id;
   logic [2*WIDTH-1:0]       resp_product;
   logic                     resp_err;
   logic                     busy;

   // Arbiter side.
   modport slave (
      input  req, req_mer, req_mand, mult_product, mult_done,
      output gnt, mult_go, mult_mer, mult_mand,
             resp_valid, resp_id, resp_product, resp_err, busy
   );

   // Clients plus multiplier side.
   modport master (
      output req, req_mer, req_mand, mult_product, mult_done,
      input  gnt, mult_go, mult_mer, mult_mand,
             resp_valid, resp_id, resp_product, resp_err, busy
   );

endinterface

`default_nettype wire

// File: rtl/mult_arbiter_rr_picker.sv
// ==== rr_picker : first set request at or after rr_ptr, wrapping modulo NUM_REQ (rev 1.0) ====
`default_nettype none

module rr_picker #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [ID_W-1:0]    rr_ptr_i,
   output logic               any_o,
   output logic [ID_W-1:0]    winner_o
);

   logic            found;
   logic [ID_W-1:0] idx_v;

   always_comb begin
      any_o    = |req_i;
      winner_o = '0;
      found    = 1'b0;
      idx_v    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx_v = ID_W'((int'(rr_ptr_i) + k) % NUM_REQ);
         if (!found && req_i[idx_v]) begin
            winner_o = idx_v;
            found    = 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/mult_arbiter.sv
// ==== mult_arbiter : round-robin front end sharing one sequential multiplier (rev 1.0) ====
`default_nettype none

module mult_arbiter
   import mult_arb_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int ID_W    = 2,
   parameter int WIDTH   = DEF_WIDTH,
   parameter int TIMEOUT = DEF_TIMEOUT,
   parameter int TO_W    = 7
) (
   input  logic           clk,
   input  logic           reset,
   mult_arbiter_if.slave  arb_io
);

   localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT - 1);
   localparam logic [ID_W-1:0] LAST_ID  = ID_W'(NUM_REQ - 1);

   arb_state_t           state_q;
   logic [ID_W-1:0]      rr_ptr_q;
   logic [TO_W-1:0]      to_cnt_q;
   logic [ID_W-1:0]      id_q;
   logic [2*WIDTH-1:0]   prod_q;
   logic                 err_q;

   logic [NUM_REQ-1:0]   gnt_q;
   logic                 go_q;
   logic [WIDTH-1:0]     mer_q;
   logic [WIDTH-1:0]     mand_q;
   logic                 resp_valid_q;
   logic [ID_W-1:0]      resp_id_q;
   logic [2*WIDTH-1:0]   resp_product_q;
   logic                 resp_err_q;
   logic                 busy_q;

   logic                 any_w;
   logic [ID_W-1:0]      winner_w;
   logic [MAX_BUS-1:0]   mer_bus_w;
   logic [MAX_BUS-1:0]   mand_bus_w;
   logic [WIDTH-1:0]     mer_d;
   logic [WIDTH-1:0]     mand_d;
   logic [NUM_REQ-1:0]   gnt_d;
   logic [ID_W-1:0]      rr_ptr_d;

   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_picker (
      .req_i    (arb_io.req),
      .rr_ptr_i (rr_ptr_q),
      .any_o    (any_w),
      .winner_o (winner_w)
   );

   assign mer_bus_w  = MAX_BUS'(arb_io.req_mer);
   assign mand_bus_w = MAX_BUS'(arb_io.req_mand);
   assign mer_d      = WIDTH'(bus_slice(mer_bus_w,  32'(winner_w), WIDTH));
   assign mand_d     = WIDTH'(bus_slice(mand_bus_w, 32'(winner_w), WIDTH));
   assign gnt_d      = NUM_REQ'(1) << winner_w;
   assign rr_ptr_d   = (id_q == LAST_ID) ? '0 : id_q + ID_W'(1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= IDLE;
         rr_ptr_q       <= '0;
         to_cnt_q       <= '0;
         id_q           <= '0;
         prod_q         <= '0;
         err_q          <= 1'b0;
         gnt_q          <= '0;
         go_q           <= 1'b0;
         mer_q          <= '0;
         mand_q         <= '0;
         resp_valid_q   <= 1'b0;
         resp_id_q      <= '0;
         resp_product_q <= '0;
         resp_err_q     <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         gnt_q        <= '0;
         go_q         <= 1'b0;
         resp_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (any_w) begin
                  mer_q   <= mer_d;
                  mand_q  <= mand_d;
                  id_q    <= winner_w;
                  gnt_q   <= gnt_d;
                  go_q    <= 1'b1;
                  busy_q  <= 1'b1;
                  state_q <= LAUNCH;
               end
            end
            LAUNCH: begin
               to_cnt_q <= '0;
               state_q  <= WAIT;
            end
            WAIT: begin
               to_cnt_q <= to_cnt_q + TO_W'(1);
               // A done seen in the first WAIT cycle may be left over from the previous operation.
               if ((to_cnt_q != '0) && arb_io.mult_done) begin
                  prod_q  <= arb_io.mult_product;
                  err_q   <= 1'b0;
                  state_q <= RESP;
               end else if (to_cnt_q == TO_LAST) begin
                  prod_q  <= '0;
                  err_q   <= 1'b1;
                  state_q <= RESP;
               end
            end
            RESP: begin
               resp_valid_q   <= 1'b1;
               resp_id_q      <= id_q;
               resp_product_q <= prod_q;
               resp_err_q     <= err_q;
               rr_ptr_q       <= rr_ptr_d;
               busy_q         <= 1'b0;
               state_q        <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign arb_io.gnt          = gnt_q;
   assign arb_io.mult_go      = go_q;
   assign arb_io.mult_mer     = mer_q;
   assign arb_io.mult_mand    = mand_q;
   assign arb_io.resp_valid   = resp_valid_q;
   assign arb_io.resp_id      = resp_id_q;
   assign arb_io.resp_product = resp_product_q;
   assign arb_io.resp_err     = resp_err_q;
   assign arb_io.busy         = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_mult_arbiter.sv
// ==== tb_mult_arbiter : directed self-checking bench for mult_arbiter (rev 1.0) ====
`default_nettype none

module tb_mult_arbiter;

   localparam int NUM_REQ = 4;
   localparam int ID_W    = 2;
   localparam int WIDTH   = 16;
   localparam int TIMEOUT = 64;
   localparam int TO_W    = 7;

   logic       clk = 1'b0;
   logic       reset;
   int         checks = 0;
   int         failures = 0;
   bit         stub_en = 1'b1;
   logic [5:0] stub_cnt;

   mult_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .WIDTH(WIDTH)) bus ();

   mult_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W),
      .WIDTH   (WIDTH),
      .TIMEOUT (TIMEOUT),
      .TO_W    (TO_W)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .arb_io (bus)
   );

   always #5 clk = ~clk;

   // Multiplier stub: done rises 34 cycles after go, cleared the cycle after go.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         stub_cnt         <= '0;
         bus.mult_done    <= 1'b0;
         bus.mult_product <= '0;
      end else if (bus.mult_go) begin
         bus.mult_done    <= 1'b0;
         bus.mult_product <= 32'(bus.mult_mer) * 32'(bus.mult_mand);
         stub_cnt         <= stub_en ? 6'd33 : 6'd0;
      end else if (stub_cnt != 0) begin
         stub_cnt <= stub_cnt - 6'd1;
         if (stub_cnt == 6'd1) bus.mult_done <= 1'b1;
      end
   end

   task automatic set_ops(input int idx, input logic [15:0] mer, input logic [15:0] mand);
      bus.req_mer[idx*WIDTH +: WIDTH]  = mer;
      bus.req_mand[idx*WIDTH +: WIDTH] = mand;
   endtask

   task automatic apply_reset();
      bus.req = '0;
      reset   = 1'b1;
      repeat (2) @(negedge clk);
      reset   = 1'b0;
      @(negedge clk);
   endtask

   // Waits for a grant, optionally drops that request, then waits for the response.
   task automatic serve_op(input bit drop, output logic [3:0] g, output logic [15:0] mer,
                           output logic [15:0] mand, output logic [1:0] id,
                           output logic [31:0] prod, output logic err, output int lat,
                           output int gos, output int ngnt);
      int n;
      g = '0; mer = '0; mand = '0; id = '0; prod = '0; err = 1'b0;
      lat = 0; gos = 0; ngnt = 0; n = 0;
      while (bus.gnt === '0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (bus.gnt === '0) begin
         checks++; failures++;
         $display("FAIL gnt_wait: got no gnt within 200 cycles, required a gnt pulse");
         return;
      end
      g = bus.gnt; mer = bus.mult_mer; mand = bus.mult_mand;
      while (bus.resp_valid !== 1'b1 && lat < 300) begin
         if (bus.mult_go === 1'b1) gos++;
         if (bus.gnt !== '0) ngnt++;
         @(negedge clk);
         lat++;
         if (lat == 1 && drop) bus.req = bus.req & ~g;
      end
      if (bus.resp_valid !== 1'b1) begin
         checks++; failures++;
         $display("FAIL resp_wait: got no resp_valid within 300 cycles of gnt, required one");
         return;
      end
      id = bus.resp_id; prod = bus.resp_product; err = bus.resp_err;
   endtask

   task automatic test_reset();
      bus.req = '0; bus.req_mer = '0; bus.req_mand = '0;
      reset = 1'b0;
      #1 reset = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({bus.busy, bus.gnt, bus.mult_go} !== 6'b0) begin
         failures++;
         $display("FAIL reset_ctrl: busy/gnt/go=%b, required 0", {bus.busy, bus.gnt, bus.mult_go});
      end
      checks++;
      if ({bus.mult_mer, bus.mult_mand} !== 32'h0) begin
         failures++;
         $display("FAIL reset_ops: mer/mand=%h, required 0", {bus.mult_mer, bus.mult_mand});
      end
      checks++;
      if ({bus.resp_valid, bus.resp_id, bus.resp_product, bus.resp_err} !== 36'h0) begin
         failures++;
         $display("FAIL reset_resp: resp fields=%h, required 0",
                  {bus.resp_valid, bus.resp_id, bus.resp_product, bus.resp_err});
      end
      reset = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL idle_no_req: busy=%b, required 0", bus.busy);
      end
   endtask

   task automatic test_single();
      logic [3:0] g; logic [15:0] mer, mand; logic [1:0] id; logic [31:0] prod; logic err;
      int lat, gos, ngnt;
      apply_reset();
      set_ops(0, 16'd3, 16'd5);
      bus.req = 4'b0001;
      serve_op(1'b1, g, mer, mand, id, prod, err, lat, gos, ngnt);
      checks++;
      if (g !== 4'b0001) begin failures++; $display("FAIL single_gnt: gnt=%b, required 0001", g); end
      checks++;
      if (mer !== 16'd3 || mand !== 16'd5) begin
         failures++; $display("FAIL single_ops: mer=%0d mand=%0d, required 3 and 5", mer, mand);
      end
      checks++;
      if (gos !== 1) begin failures++; $display("FAIL single_go: go pulses=%0d, required 1", gos); end
      checks++;
      if (id !== 2'd0 || prod !== 32'd15 || err !== 1'b0) begin
         failures++;
         $display("FAIL single_resp: id=%0d prod=%0d err=%b, required 0, 15, 0", id, prod, err);
      end
      checks++;
      if (lat !== 36) begin failures++; $display("FAIL single_lat: gnt->resp=%0d, required 36", lat); end
      @(negedge clk);
      checks++;
      if (bus.resp_valid !== 1'b0 || bus.resp_product !== 32'd15) begin
         failures++;
         $display("FAIL resp_hold: valid=%b prod=%0d, required 0 and 15", bus.resp_valid, bus.resp_product);
      end
   endtask

   task automatic test_simultaneous();
      logic [3:0] g; logic [15:0] mer, mand; logic [1:0] id; logic [31:0] prod; logic err;
      int lat, gos, ngnt;
      apply_reset();
      set_ops(1, 16'd7, 16'd9);
      set_ops(2, 16'd100, 16'd200);
      bus.req = 4'b0110;
      serve_op(1'b1, g, mer, mand, id, prod, err, lat, gos, ngnt);
      checks++;
      if (g !== 4'b0010 || id !== 2'd1 || prod !== 32'd63) begin
         failures++;
         $display("FAIL simul_first: gnt=%b id=%0d prod=%0d, required 0010, 1, 63", g, id, prod);
      end
      serve_op(1'b1, g, mer, mand, id, prod, err, lat, gos, ngnt);
      checks++;
      if (g !== 4'b0100 || id !== 2'd2 || prod !== 32'd20000) begin
         failures++;
         $display("FAIL simul_second: gnt=%b id=%0d prod=%0d, required 0100, 2, 20000", g, id, prod);
      end
   endtask

   task automatic test_round_robin();
      logic [3:0] g; logic [15:0] mer, mand; logic [1:0] id; logic [31:0] prod; logic err;
      int lat, gos, ngnt;
      logic [3:0]  exp_g [4]  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
      logic [31:0] exp_p [4]  = '{32'd2, 32'd6, 32'd12, 32'd20};
      apply_reset();
      for (int i = 0; i < 4; i++) set_ops(i, 16'(i + 1), 16'(i + 2));
      bus.req = 4'b1111;
      for (int op = 0; op < 8; op++) begin
         serve_op(1'b0, g, mer, mand, id, prod, err, lat, gos, ngnt);
         checks++;
         if (id !== 2'(op % 4) || prod !== exp_p[op % 4]) begin
            failures++;
            $display("FAIL rr_op%0d: id=%0d prod=%0d, required %0d and %0d",
                     op, id, prod, op % 4, exp_p[op % 4]);
         end
         checks++;
         if (g !== exp_g[op % 4] || ngnt !== 1 || gos !== 1) begin
            failures++;
            $display("FAIL rr_gnt%0d: gnt=%b gnt_cycles=%0d go=%0d, required %b, 1, 1",
                     op, g, ngnt, gos, exp_g[op % 4]);
         end
      end
      bus.req = '0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_timeout();
      logic [3:0] g; logic [15:0] mer, mand; logic [1:0] id; logic [31:0] prod; logic err;
      int lat, gos, ngnt;
      apply_reset();
      stub_en = 1'b0;
      set_ops(3, 16'd9, 16'd9);
      bus.req = 4'b1000;
      serve_op(1'b1, g, mer, mand, id, prod, err, lat, gos, ngnt);
      checks++;
      if (id !== 2'd3 || err !== 1'b1 || prod !== 32'd0) begin
         failures++;
         $display("FAIL timeout_resp: id=%0d err=%b prod=%0d, required 3, 1, 0", id, err, prod);
      end
      checks++;
      if (lat !== TIMEOUT + 2) begin
         failures++; $display("FAIL timeout_lat: gnt->resp=%0d, required %0d", lat, TIMEOUT + 2);
      end
      stub_en = 1'b1;
      set_ops(0, 16'd2, 16'd21);
      bus.req = 4'b1001;
      serve_op(1'b1, g, mer, mand, id, prod, err, lat, gos, ngnt);
      checks++;
      if (id !== 2'd0 || prod !== 32'd42 || err !== 1'b0) begin
         failures++;
         $display("FAIL ptr_wrap: id=%0d prod=%0d err=%b, required 0, 42, 0", id, prod, err);
      end
      bus.req = '0;
   endtask

   task automatic test_reset_mid_and_extreme();
      logic [3:0] g; logic [15:0] mer, mand; logic [1:0] id; logic [31:0] prod; logic err;
      int lat, gos, ngnt, n, pulses;
      set_ops(2, 16'd11, 16'd13);
      bus.req = 4'b0100;
      n = 0;
      while (bus.gnt === '0 && n < 50) begin @(negedge clk); n++; end
      checks++;
      if (bus.gnt !== 4'b0100) begin
         failures++; $display("FAIL mid_gnt: gnt=%b, required 0100", bus.gnt);
      end
      @(negedge clk);
      bus.req = '0;
      repeat (5) @(negedge clk);
      reset = 1'b1;
      #1;
      checks++;
      if ({bus.busy, bus.gnt, bus.mult_go, bus.mult_mer, bus.mult_mand} !== 38'h0) begin
         failures++;
         $display("FAIL mid_reset_ctrl: busy/gnt/go/mer/mand=%h, required 0",
                  {bus.busy, bus.gnt, bus.mult_go, bus.mult_mer, bus.mult_mand});
      end
      checks++;
      if ({bus.resp_valid, bus.resp_id, bus.resp_product, bus.resp_err} !== 36'h0) begin
         failures++;
         $display("FAIL mid_reset_resp: resp fields=%h, required 0",
                  {bus.resp_valid, bus.resp_id, bus.resp_product, bus.resp_err});
      end
      @(negedge clk);
      reset = 1'b0;
      pulses = 0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (bus.resp_valid === 1'b1) pulses++;
      end
      checks++;
      if (pulses !== 0) begin
         failures++; $display("FAIL mid_no_resp: resp pulses=%0d, required 0", pulses);
      end
      set_ops(0, 16'hFFFF, 16'hFFFF);
      set_ops(3, 16'd1, 16'd1);
      bus.req = 4'b1001;
      serve_op(1'b1, g, mer, mand, id, prod, err, lat, gos, ngnt);
      checks++;
      if (id !== 2'd0 || prod !== 32'hFFFE0001 || err !== 1'b0) begin
         failures++;
         $display("FAIL extreme: id=%0d prod=%h err=%b, required 0, fffe0001, 0", id, prod, err);
      end
      bus.req = '0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_simultaneous();
      test_round_robin();
      test_timeout();
      test_reset_mid_and_extreme();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
